// File: rtl/rom_load_arb_if.sv
// rom_load_arb_if
//   Word-wide request/acknowledge memory bus used on both sides of the
//   ROM-load arbiter: the core requester (arbiter is the slave) and the
//   external memory port (arbiter is the master).
//   req   : request, held by the master until ack
//   we    : write enable
//   addr  : word address, ADDR_W bits
//   wdata : write data, 16 bits
//   be    : byte enables, 2 bits
//   ack   : one-cycle completion pulse from the slave
//   rdata : read data, valid with ack
interface rom_load_arb_if #(
   parameter int ADDR_W = 22
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       wdata;
   logic [1:0]        be;
   logic              ack;
   logic [15:0]       rdata;

   modport master (output req, we, addr, wdata, be, input  ack, rdata);
   modport slave  (input  req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/rom_load_arb.sv
// rom_load_arb
//   Shares one external memory port between the SPI ROM-load byte stream and
//   the emulated core. ROM bytes are packed little-endian into 16-bit words,
//   queued in a small FIFO and written to sequential addresses starting at
//   BASE_ADDR. The loader has priority; the core is held off while a load
//   session is active or still draining.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   rom_loading    : load session active (level)
//   rom_do         : ROM byte, valid with rom_do_valid strobe
//   core_bus       : core requester (slave side of the bus)
//   mem_bus        : external memory port (master side of the bus)
//   load_busy      : session active or data still draining
//   load_done      : one-cycle pulse when a session has fully drained
//   load_overflow  : sticky, a packed word was dropped because the FIFO was full
//   load_words     : words written in the current/last session
module rom_load_arb #(
   parameter int                ADDR_W     = 22,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rom_loading,
   input  logic [7:0]        rom_do,
   input  logic              rom_do_valid,
   rom_load_arb_if.slave     core_bus,
   rom_load_arb_if.master    mem_bus,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_overflow,
   output logic [ADDR_W-1:0] load_words
);
   localparam int                PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD_WR  = 2'd1,
      ST_CORE_ACC = 2'd2
   } state_t;

   state_t            state_r, state_nx_s;
   logic              start_load_s, start_core_s;

   logic              loading_q_r;
   logic              phase_odd_r;
   logic [7:0]        low_byte_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [ADDR_W-1:0] words_r;
   logic              overflow_r;
   logic              busy_r;
   logic              done_r;

   // FIFO entry layout: {be[1:0], data[15:0]}
   logic [17:0]       fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
   logic [PTR_W:0]    fifo_cnt_r;
   logic [17:0]       fifo_head_s;

   logic              mem_req_r, mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [15:0]       mem_wdata_r;
   logic [1:0]        mem_be_r;
   logic              core_ack_r;
   logic [15:0]       core_rdata_r;

   logic              rise_s, fall_s, byte_s, pair_s, flush_s, push_s;
   logic              fifo_empty_s, fifo_full_s, pop_s, push_ok_s, drop_s;
   logic              busy_s;
   logic [17:0]       push_data_s;

   // Session edges, word packing, FIFO push/pop qualification and busy term
   always_comb begin
      rise_s       = rom_loading & ~loading_q_r;
      fall_s       = ~rom_loading & loading_q_r;
      byte_s       = rom_loading & rom_do_valid;
      // A byte arriving on the session's first cycle always starts a new word
      pair_s       = byte_s & phase_odd_r & ~rise_s;
      flush_s      = fall_s & phase_odd_r;
      push_s       = pair_s | flush_s;
      fifo_empty_s = (fifo_cnt_r == {(PTR_W+1){1'b0}});
      fifo_full_s  = (fifo_cnt_r == FULL_CNT);
      fifo_head_s  = fifo_mem_r[rd_ptr_r];
      pop_s        = (state_r == ST_LOAD_WR) & mem_bus.ack;
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
      push_ok_s    = push_s & (~fifo_full_s | pop_s);
      drop_s       = push_s & fifo_full_s & ~pop_s;
      busy_s       = rom_loading | ~fifo_empty_s | (state_r == ST_LOAD_WR) | flush_s;
      if (flush_s) begin
         push_data_s = {2'b01, 8'h00, low_byte_r};
      end else begin
         push_data_s = {2'b11, rom_do, low_byte_r};
      end
   end

   // Byte phase tracking and even-byte holding register
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_odd_r <= 1'b0;
         low_byte_r  <= 8'h00;
      end else if (byte_s) begin
         if (phase_odd_r & ~rise_s) begin
            phase_odd_r <= 1'b0;
         end else begin
            low_byte_r  <= rom_do;
            phase_odd_r <= 1'b1;
         end
      end else if (rise_s | flush_s) begin
         phase_odd_r <= 1'b0;
      end
   end

   // Session bookkeeping: write address, word count, sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         loading_q_r <= 1'b0;
         wr_addr_r   <= BASE_ADDR;
         words_r     <= {ADDR_W{1'b0}};
         overflow_r  <= 1'b0;
      end else begin
         loading_q_r <= rom_loading;
         if (rise_s) begin
            wr_addr_r <= BASE_ADDR;
            words_r   <= {ADDR_W{1'b0}};
         end else if (pop_s) begin
            wr_addr_r <= wr_addr_r + ADDR_ONE;
            words_r   <= words_r + ADDR_ONE;
         end
         if (rise_s) begin
            overflow_r <= 1'b0;
         end else if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Registered busy flag and drain-complete pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_s;
         done_r <= busy_r & ~busy_s;
      end
   end

   // FIFO storage (contents need no reset, pointers define validity)
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         fifo_mem_r[wr_ptr_r] <= push_data_s;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         fifo_cnt_r <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_s})
            2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
            2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
            default: fifo_cnt_r <= fifo_cnt_r;
         endcase
      end
   end

   // Arbiter state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Arbiter next state: loader first, core only once loading has fully drained
   always_comb begin
      state_nx_s   = state_r;
      start_load_s = 1'b0;
      start_core_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               state_nx_s   = ST_LOAD_WR;
               start_load_s = 1'b1;
            // core_req is still high in the cycle its ack is presented; that
            // request is already served and must not start a second access
            end else if (core_bus.req && !busy_s && !core_ack_r) begin
               state_nx_s   = ST_CORE_ACC;
               start_core_s = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LOAD_WR, ST_CORE_ACC: begin
            if (mem_bus.ack) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = state_r;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Memory port registers, loaded on leaving IDLE and released on ack
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= 16'h0000;
         mem_be_r    <= 2'b00;
      end else if (start_load_s) begin
         mem_req_r   <= 1'b1;
         mem_we_r    <= 1'b1;
         mem_addr_r  <= wr_addr_r;
         mem_wdata_r <= fifo_head_s[15:0];
         mem_be_r    <= fifo_head_s[17:16];
      end else if (start_core_s) begin
         mem_req_r   <= 1'b1;
         mem_we_r    <= core_bus.we;
         mem_addr_r  <= core_bus.addr;
         mem_wdata_r <= core_bus.wdata;
         mem_be_r    <= core_bus.be;
      end else if ((state_r != ST_IDLE) && mem_bus.ack) begin
         mem_req_r <= 1'b0;
      end
   end

   // Core completion: ack pulse and read data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         core_ack_r   <= 1'b0;
         core_rdata_r <= 16'h0000;
      end else begin
         core_ack_r <= (state_r == ST_CORE_ACC) & mem_bus.ack;
         if ((state_r == ST_CORE_ACC) && mem_bus.ack && !mem_we_r) begin
            core_rdata_r <= mem_bus.rdata;
         end
      end
   end

   assign mem_bus.req    = mem_req_r;
   assign mem_bus.we     = mem_we_r;
   assign mem_bus.addr   = mem_addr_r;
   assign mem_bus.wdata  = mem_wdata_r;
   assign mem_bus.be     = mem_be_r;
   assign core_bus.ack   = core_ack_r;
   assign core_bus.rdata = core_rdata_r;
   assign load_busy      = busy_r;
   assign load_done      = done_r;
   assign load_overflow  = overflow_r;
   assign load_words     = words_r;
endmodule

// File: tb/tb_rom_load_arb.sv
// Testbench for rom_load_arb: directed and randomized load sessions plus core
// accesses against a memory responder; expected writes come from a packing
// model that works on whole byte lists.
module tb_rom_load_arb;
   localparam int          AW   = 22;
   localparam logic [21:0] BASE = 22'h000100;

   typedef struct packed {
      logic [21:0] addr;
      logic [15:0] data;
      logic [1:0]  be;
   } wr_t;
   typedef wr_t        wr_q_t[$];
   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        reset;
   logic        rom_loading, rom_do_valid;
   logic [7:0]  rom_do;
   logic        load_busy, load_done, load_overflow;
   logic [21:0] load_words;

   rom_load_arb_if #(.ADDR_W(AW)) core_if ();
   rom_load_arb_if #(.ADDR_W(AW)) mem_if ();

   rom_load_arb #(.ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .rom_loading  (rom_loading),
      .rom_do       (rom_do),
      .rom_do_valid (rom_do_valid),
      .core_bus     (core_if),
      .mem_bus      (mem_if),
      .load_busy    (load_busy),
      .load_done    (load_done),
      .load_overflow(load_overflow),
      .load_words   (load_words)
   );

   always #5 clk = ~clk;

   int          n_checks = 0, n_pass = 0;
   int          req_cycles = 0, ack_cnt = 0, done_cnt = 0, proto_err = 0;
   int          ack_delay = 1, wait_cnt = 0;
   logic        hold = 1'b0, prev_ack = 1'b0;
   logic [15:0] rd_data = 16'h0000;
   logic [21:0] rd_addr_last = 22'h0;
   wr_q_t       wr_q;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Packing rule: pairs of bytes -> {odd,even} be=11, a trailing byte -> {00,byte} be=01
   function automatic wr_q_t model_writes(input byte_q_t b, input logic [21:0] base);
      wr_q_t q;
      wr_t   w;
      for (int i = 0; i < b.size(); i += 2) begin
         w.addr = base + 22'(i / 2);
         if (i + 1 < b.size()) begin
            w.data = {b[i+1], b[i]};
            w.be   = 2'b11;
         end else begin
            w.data = {8'h00, b[i]};
            w.be   = 2'b01;
         end
         q.push_back(w);
      end
      return q;
   endfunction

   task automatic compare_writes(input string tag, input wr_q_t exp);
      check($sformatf("%s_nwrites", tag), 64'(wr_q.size()), 64'(exp.size()));
      for (int i = 0; i < exp.size() && i < wr_q.size(); i++)
         check($sformatf("%s_write%0d", tag, i), 64'(wr_q[i]), 64'(exp[i]));
   endtask

   // Memory responder and bus monitor, acting on the falling edge
   initial begin
      mem_if.ack   = 1'b0;
      mem_if.rdata = 16'h0000;
      forever begin
         @(negedge clk);
         mem_if.ack   = 1'b0;
         mem_if.rdata = 16'($urandom);
         if (mem_if.req) req_cycles++;
         if (core_if.ack) ack_cnt++;
         if (load_done) done_cnt++;
         if (prev_ack && mem_if.req) proto_err++;
         prev_ack = 1'b0;
         if (mem_if.req && !reset && !hold) begin
            if (wait_cnt >= ack_delay) begin
               mem_if.ack   = 1'b1;
               mem_if.rdata = rd_data;
               prev_ack     = 1'b1;
               wait_cnt     = 0;
               if (mem_if.we) wr_q.push_back('{mem_if.addr, mem_if.wdata, mem_if.be});
               else rd_addr_last = mem_if.addr;
            end else begin
               wait_cnt++;
            end
         end else if (!mem_if.req) begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rom_do       = b;
      rom_do_valid = 1'b1;
      @(negedge clk);
      rom_do_valid = 1'b0;
      rom_do       = 8'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      repeat (2) @(negedge clk);
      while ((load_busy || mem_if.req) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s_drain_in_time", tag), 64'(n < 1000), 64'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic end_session(input string tag);
      @(negedge clk);
      rom_loading = 1'b0;
      wait_drain(tag);
   endtask

   task automatic core_start(input logic we, input logic [21:0] a, input logic [15:0] d,
                             input logic [1:0] be);
      @(negedge clk);
      core_if.req   = 1'b1;
      core_if.we    = we;
      core_if.addr  = a;
      core_if.wdata = d;
      core_if.be    = be;
   endtask

   task automatic core_wait(input string tag);
      int n = 0;
      @(negedge clk);
      while (!core_if.ack && n < 400) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s_core_ack_in_time", tag), 64'(n < 400), 64'd1);
      core_if.req = 1'b0;
   endtask

   initial begin
      byte_q_t     bq;
      int          d0, a0, r0, nwr, nb, gap;
      logic [21:0] ca;
      logic [15:0] cd;
      logic [1:0]  cb;

      reset = 1'b1; rom_loading = 1'b0; rom_do = 8'h00; rom_do_valid = 1'b0;
      core_if.req = 1'b0; core_if.we = 1'b0; core_if.addr = 22'h0;
      core_if.wdata = 16'h0; core_if.be = 2'b00;
      repeat (3) @(negedge clk);
      check("rst_mem_req", 64'(mem_if.req), 64'd0);
      check("rst_mem_we", 64'(mem_if.we), 64'd0);
      check("rst_mem_addr", 64'(mem_if.addr), 64'd0);
      check("rst_core_ack", 64'(core_if.ack), 64'd0);
      check("rst_core_rdata", 64'(core_if.rdata), 64'd0);
      check("rst_busy", 64'(load_busy), 64'd0);
      check("rst_done", 64'(load_done), 64'd0);
      check("rst_overflow", 64'(load_overflow), 64'd0);
      check("rst_words", 64'(load_words), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Four bytes, ack one cycle after request, with latency probe
      wr_q.delete(); d0 = done_cnt; ack_delay = 1;
      @(negedge clk); rom_loading = 1'b1;
      send_byte(8'h11, 6);
      send_byte(8'h22, 0);
      check("lat_n1_req_low", 64'(mem_if.req), 64'd0);
      @(negedge clk);
      check("lat_n2_req_high", 64'(mem_if.req), 64'd1);
      repeat (6) @(negedge clk);
      send_byte(8'h33, 6);
      send_byte(8'h44, 6);
      end_session("t1");
      bq = {8'h11, 8'h22, 8'h33, 8'h44};
      compare_writes("t1", model_writes(bq, BASE));
      check("t1_words", 64'(load_words), 64'd2);
      check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);

      // Odd byte count flush; strobe outside a session is ignored
      wr_q.delete();
      send_byte(8'hEE, 2);
      @(negedge clk); rom_loading = 1'b1;
      send_byte(8'hAA, 5); send_byte(8'hBB, 5); send_byte(8'hCC, 5);
      end_session("t2");
      bq = {8'hAA, 8'hBB, 8'hCC};
      compare_writes("t2", model_writes(bq, BASE));
      check("t2_words", 64'(load_words), 64'd2);

      // Memory stalled while 12 bytes stream in
      wr_q.delete(); hold = 1'b1; bq.delete();
      @(negedge clk); rom_loading = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bq.push_back(8'($urandom));
         send_byte(bq[i], 2);
         if (i == 7) check("t3_no_overflow_at_8", 64'(load_overflow), 64'd0);
      end
      repeat (150) @(negedge clk);
      check("t3_overflow_set", 64'(load_overflow), 64'd1);
      check("t3_req_held", 64'(mem_if.req), 64'd1);
      check("t3_no_writes_while_stalled", 64'(wr_q.size()), 64'd0);
      @(negedge clk); rom_loading = 1'b0; hold = 1'b0;
      wait_drain("t3");
      bq = bq[0:7];
      compare_writes("t3", model_writes(bq, BASE));
      check("t3_words", 64'(load_words), 64'd4);
      check("t3_overflow_sticky", 64'(load_overflow), 64'd1);
      wr_q.delete();
      @(negedge clk); rom_loading = 1'b1;
      repeat (2) @(negedge clk);
      check("t3_rise_clears_overflow", 64'(load_overflow), 64'd0);
      check("t3_rise_clears_words", 64'(load_words), 64'd0);
      send_byte(8'h5A, 5); send_byte(8'hA5, 5);
      end_session("t3b");
      bq = {8'h5A, 8'hA5};
      compare_writes("t3b", model_writes(bq, BASE));

      // Core read with a three-cycle memory delay
      ack_delay = 3; rd_data = 16'h1234; r0 = req_cycles; a0 = ack_cnt;
      core_start(1'b0, 22'd5, 16'h0000, 2'b11);
      core_wait("t4r");
      repeat (3) @(negedge clk);
      check("t4_rdata", 64'(core_if.rdata), 64'h1234);
      check("t4_read_addr", 64'(rd_addr_last), 64'd5);
      check("t4_req_cycles", 64'(req_cycles - r0), 64'd4);
      check("t4_ack_pulses", 64'(ack_cnt - a0), 64'd1);

      // Core write leaves core_rdata alone
      wr_q.delete(); ack_delay = 2;
      ca = 22'($urandom); cd = 16'($urandom); cb = 2'($urandom_range(1, 3));
      core_start(1'b1, ca, cd, cb);
      core_wait("t4w");
      repeat (2) @(negedge clk);
      check("t4w_nwrites", 64'(wr_q.size()), 64'd1);
      if (wr_q.size() > 0) check("t4w_write", 64'(wr_q[0]), 64'({ca, cd, cb}));
      check("t4w_rdata_kept", 64'(core_if.rdata), 64'h1234);

      // Core request raised during a session waits for the drain
      wr_q.delete(); ack_delay = 1; rd_data = 16'hBEEF; a0 = ack_cnt;
      @(negedge clk); rom_loading = 1'b1;
      core_start(1'b0, 22'd9, 16'h0000, 2'b11);
      bq.delete();
      for (int i = 0; i < 3; i++) begin
         bq.push_back(8'($urandom));
         send_byte(bq[i], 4);
      end
      check("t5_no_ack_in_session", 64'(ack_cnt - a0), 64'd0);
      @(negedge clk); rom_loading = 1'b0;
      core_wait("t5");
      nwr = wr_q.size();
      check("t5_loads_before_core", 64'(nwr), 64'd2);
      repeat (3) @(negedge clk);
      check("t5_rdata", 64'(core_if.rdata), 64'hBEEF);
      check("t5_read_addr", 64'(rd_addr_last), 64'd9);
      compare_writes("t5", model_writes(bq, BASE));

      // Randomized sessions
      for (int s = 0; s < 4; s++) begin
         wr_q.delete(); bq.delete(); d0 = done_cnt;
         nb = $urandom_range(1, 7); gap = $urandom_range(6, 10);
         ack_delay = $urandom_range(0, 3);
         @(negedge clk); rom_loading = 1'b1;
         for (int i = 0; i < nb; i++) begin
            bq.push_back(8'($urandom));
            send_byte(bq[i], gap);
         end
         end_session($sformatf("r%0d", s));
         compare_writes($sformatf("r%0d", s), model_writes(bq, BASE));
         check($sformatf("r%0d_words", s), 64'(load_words), 64'((nb + 1) / 2));
         check($sformatf("r%0d_overflow", s), 64'(load_overflow), 64'd0);
         check($sformatf("r%0d_done", s), 64'(done_cnt - d0), 64'd1);
      end

      // Reset while a load write is in flight
      wr_q.delete(); hold = 1'b1; a0 = ack_cnt;
      @(negedge clk); rom_loading = 1'b1;
      send_byte(8'h01, 0); send_byte(8'h02, 0);
      nwr = 0;
      while (!mem_if.req && nwr < 20) begin
         @(negedge clk);
         nwr++;
      end
      check("t6_in_load_wr", 64'(mem_if.req), 64'd1);
      reset = 1'b1; rom_loading = 1'b0;
      @(negedge clk);
      check("t6_req_dropped", 64'(mem_if.req), 64'd0);
      check("t6_words", 64'(load_words), 64'd0);
      check("t6_busy", 64'(load_busy), 64'd0);
      check("t6_we", 64'(mem_if.we), 64'd0);
      check("t6_core_ack", 64'(core_if.ack), 64'd0);
      reset = 1'b0; hold = 1'b0;
      repeat (10) @(negedge clk);
      check("t6_fifo_empty_no_req", 64'(mem_if.req), 64'd0);
      check("t6_no_writes", 64'(wr_q.size()), 64'd0);
      check("t6_no_core_ack", 64'(ack_cnt - a0), 64'd0);

      check("req_after_ack_violations", 64'(proto_err), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
